// File: rtl/pe_inject_eject_if.sv
`default_nettype none
// ============================================================================
// Module   : pe_inject_eject_if
// Purpose  : PE-side interface stage for one 3D CHIPPER router node.
//            Injection path buffers PE flits in a small FIFO and offers the
//            head flit to the router PE port. A head flit that is left
//            ungranted for too long gets its golden bit [25] forced so that it
//            wins deflection arbitration. Ejection path registers every
//            nonzero flit leaving the router toward the PE.
//            Flit format: [31:30] X dest, [29:28] Y dest, [27:26] Z dest,
//            [25] golden/priority, [24:0] payload. 32'h0 means "no flit".
// Ports    :
//   clk                in   1   single clock, rising edge
//   rst_n              in   1   asynchronous active-low reset
//   i_pe_wr_valid      in   1   PE offers a flit this cycle
//   i_pe_wr_data       in   32  PE flit to inject
//   o_pe_wr_ready      out  1   FIFO can accept (not full)
//   o_inj_flit         out  32  head flit to router PEIN, 32'h0 when empty
//   o_inject_request   out  1   FIFO not empty
//   i_inject_grant     in   1   router consumes head flit this cycle
//   i_ej_flit_in       in   32  flit from router PEOUT, 32'h0 = none
//   o_pe_rd_valid      out  1   ejected flit valid (one cycle per flit)
//   o_pe_rd_data       out  32  registered ejected flit
//   o_starve_flag      out  1   head is currently golden-promoted
//   o_zero_drop        out  1   pulse: PE wrote 32'h0, flit discarded
//   o_inj_count        out  CW  flits granted into router (wraps)
//   o_ej_count         out  CW  flits ejected to PE (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module pe_inject_eject_if #(
  parameter int DEPTH        = 4,
  parameter int AW           = 2,
  parameter int STARVE_LIMIT = 8,
  parameter int CW           = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_pe_wr_valid,
  input  logic [31:0]   i_pe_wr_data,
  output logic          o_pe_wr_ready,
  output logic [31:0]   o_inj_flit,
  output logic          o_inject_request,
  input  logic          i_inject_grant,
  input  logic [31:0]   i_ej_flit_in,
  output logic          o_pe_rd_valid,
  output logic [31:0]   o_pe_rd_data,
  output logic          o_starve_flag,
  output logic          o_zero_drop,
  output logic [CW-1:0] o_inj_count,
  output logic [CW-1:0] o_ej_count
);

  // Starve counter needs to hold STARVE_LIMIT itself (the saturated value).
  localparam int            c_SW        = $clog2(STARVE_LIMIT + 1);
  localparam logic [c_SW-1:0] c_STARVE_MAX = c_SW'(STARVE_LIMIT);
  localparam logic [AW:0]   c_FULL      = (AW + 1)'(DEPTH);

  // --------------------------------------------------------------------------
  // Injection FIFO state
  // --------------------------------------------------------------------------
  logic [31:0]     r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic [c_SW-1:0] r_starve_cnt;

  logic            w_empty;
  logic            w_full;
  logic            w_push;
  logic            w_pop;
  logic            w_zero_wr;
  logic            w_starved;
  logic [31:0]     w_head;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == c_FULL);

  // Readiness comes from registered occupancy only: a full FIFO refuses a
  // write even when the head is being granted in the same cycle.
  assign w_zero_wr = i_pe_wr_valid && (i_pe_wr_data == 32'h0);
  assign w_push    = i_pe_wr_valid && !w_full && !w_zero_wr;
  assign w_pop     = i_inject_grant && !w_empty;

  assign w_starved = (r_starve_cnt == c_STARVE_MAX);
  assign w_head    = r_mem[r_rd_ptr];

  // --------------------------------------------------------------------------
  // FIFO storage and pointers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 32'h0;
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= i_pe_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Starvation tracking: counts ungranted cycles of the current head, sticks
  // at the limit, and restarts whenever the head leaves. The golden
  // promotion therefore belongs to one head flit and never leaks to the next.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
    end else if (w_pop) begin
      r_starve_cnt <= '0;
    end else if (!w_empty && !i_inject_grant && !w_starved) begin
      r_starve_cnt <= r_starve_cnt + c_SW'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Injection counter and zero-write pulse
  // --------------------------------------------------------------------------
  logic [CW-1:0] r_inj_count;
  logic          r_zero_drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inj_count <= '0;
      r_zero_drop <= 1'b0;
    end else begin
      if (w_pop) begin
        r_inj_count <= r_inj_count + CW'(1);
      end
      r_zero_drop <= w_zero_wr;
    end
  end

  // --------------------------------------------------------------------------
  // Ejection path: no backpressure, one registered beat per nonzero flit.
  // --------------------------------------------------------------------------
  logic          r_pe_rd_valid;
  logic [31:0]   r_pe_rd_data;
  logic [CW-1:0] r_ej_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pe_rd_valid <= 1'b0;
      r_pe_rd_data  <= 32'h0;
      r_ej_count    <= '0;
    end else if (i_ej_flit_in != 32'h0) begin
      r_pe_rd_valid <= 1'b1;
      r_pe_rd_data  <= i_ej_flit_in;
      r_ej_count    <= r_ej_count + CW'(1);
    end else begin
      r_pe_rd_valid <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign o_pe_wr_ready    = !w_full;
  assign o_inject_request = !w_empty;
  // Bit 25 is OR-ed so a PE pre-promoted flit stays golden regardless of age.
  assign o_inj_flit       = w_empty ? 32'h0
                          : {w_head[31:26], w_head[25] | w_starved, w_head[24:0]};
  assign o_starve_flag    = w_starved;
  assign o_zero_drop      = r_zero_drop;
  assign o_inj_count      = r_inj_count;
  assign o_pe_rd_valid    = r_pe_rd_valid;
  assign o_pe_rd_data     = r_pe_rd_data;
  assign o_ej_count       = r_ej_count;

endmodule
`default_nettype wire
